// File: rtl/prog_load_ctrl_pkg.sv
// Shared definitions for the boot-time program loader: state encodings and
// default sizing, also used by the instruction memory and the benches.
package prog_load_ctrl_pkg;

    localparam int CELL_NUMBERS_DEFAULT = 64;
    localparam int ADDR_W_DEFAULT       = 6;

    typedef enum logic [1:0] {
        ST_LOAD  = 2'd0,
        ST_FLUSH = 2'd1,
        ST_RUN   = 2'd2
    } state_e;

endpackage

// File: rtl/prog_load_ctrl_if.sv
// UART-byte input side and instruction-memory / core-control output side of
// the program loader, bundled as one interface.
interface prog_load_ctrl_if
    import prog_load_ctrl_pkg::*;
#(
    parameter int ADDR_W = ADDR_W_DEFAULT
) ();

    logic              rx_valid;
    logic [7:0]        rx_data;
    logic              restart;
    logic              imem_we;
    logic [ADDR_W-1:0] imem_addr;
    logic [31:0]       imem_wdata;
    logic              cpu_rst;
    logic              load_done;

    // The loader itself
    modport slave (
        input  rx_valid, rx_data, restart,
        output imem_we, imem_addr, imem_wdata, cpu_rst, load_done
    );

    // The surrounding system (UART receiver, memory, core)
    modport master (
        output rx_valid, rx_data, restart,
        input  imem_we, imem_addr, imem_wdata, cpu_rst, load_done
    );

endinterface

// File: rtl/prog_load_ctrl_byte_word_asm.sv
// Little-endian byte-to-word assembler: lanes 0..2 are held until the 4th
// byte arrives, then the full word and a one-cycle word_ready are registered.
module prog_load_ctrl_byte_word_asm (
    input  logic        clk,
    input  logic        rst,
    input  logic        clr,
    input  logic        accept,
    input  logic [7:0]  rx_data,
    output logic        word_last,
    output logic        word_ready,
    output logic [31:0] word
);

    logic [1:0]  byte_cnt_q, byte_cnt_d;
    logic [23:0] lanes_q, lanes_d;
    logic        word_ready_q, word_ready_d;
    logic [31:0] word_q, word_d;

    always_comb begin
        byte_cnt_d   = byte_cnt_q;
        lanes_d      = lanes_q;
        word_ready_d = 1'b0;
        word_d       = word_q;
        word_last    = accept && (byte_cnt_q == 2'd3);
        if (clr) begin
            byte_cnt_d = '0;
            lanes_d    = '0;
        end else if (accept) begin
            byte_cnt_d = byte_cnt_q + 2'd1;
            if (word_last) begin
                word_d       = {rx_data, lanes_q};
                word_ready_d = 1'b1;
            end else begin
                case (byte_cnt_q)
                    2'd0:    lanes_d[7:0]   = rx_data;
                    2'd1:    lanes_d[15:8]  = rx_data;
                    default: lanes_d[23:16] = rx_data;
                endcase
            end
        end
    end

    // word_q keeps its value on clr so an already registered write completes
    always_ff @(posedge clk) begin
        if (rst) begin
            byte_cnt_q   <= '0;
            lanes_q      <= '0;
            word_ready_q <= 1'b0;
            word_q       <= '0;
        end else begin
            byte_cnt_q   <= byte_cnt_d;
            lanes_q      <= lanes_d;
            word_ready_q <= word_ready_d;
            word_q       <= word_d;
        end
    end

    assign word_ready = word_ready_q;
    assign word       = word_q;

endmodule

// File: rtl/prog_load_ctrl.sv
// Program loader FSM: writes CELL_NUMBERS assembled words to instruction
// memory while holding the core in reset, then releases it until restart.
module prog_load_ctrl
    import prog_load_ctrl_pkg::*;
#(
    parameter int CELL_NUMBERS = CELL_NUMBERS_DEFAULT,
    parameter int ADDR_W       = ADDR_W_DEFAULT
) (
    input  logic             clk,
    input  logic             rst,
    prog_load_ctrl_if.slave  bus
);

    localparam logic [ADDR_W-1:0] LAST_WORD = ADDR_W'(CELL_NUMBERS - 1);

    state_e            state_q, state_d;
    logic [ADDR_W-1:0] word_cnt_q, word_cnt_d;
    logic [ADDR_W-1:0] imem_addr_q, imem_addr_d;
    logic              cpu_rst_q, cpu_rst_d;
    logic              load_done_q, load_done_d;
    logic              accept;
    logic              word_last;
    logic              word_ready;
    logic [31:0]       word;

    // restart beats a coincident byte; FLUSH and RUN drop bytes
    assign accept = bus.rx_valid && (state_q == ST_LOAD) && !bus.restart;

    prog_load_ctrl_byte_word_asm u_byte_word_asm (
        .clk        (clk),
        .rst        (rst),
        .clr        (bus.restart),
        .accept     (accept),
        .rx_data    (bus.rx_data),
        .word_last  (word_last),
        .word_ready (word_ready),
        .word       (word)
    );

    always_comb begin
        state_d     = state_q;
        word_cnt_d  = word_cnt_q;
        imem_addr_d = imem_addr_q;
        if (bus.restart) begin
            state_d    = ST_LOAD;
            word_cnt_d = '0;
        end else begin
            case (state_q)
                ST_LOAD: begin
                    if (word_last) begin
                        imem_addr_d = word_cnt_q;
                        word_cnt_d  = word_cnt_q + 1'b1;
                        if (word_cnt_q == LAST_WORD) state_d = ST_FLUSH;
                    end
                end
                ST_FLUSH: state_d = ST_RUN;
                ST_RUN:   state_d = ST_RUN;
                default:  state_d = ST_LOAD;
            endcase
        end
        cpu_rst_d   = (state_d != ST_RUN);
        load_done_d = (state_d == ST_RUN);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= ST_LOAD;
            word_cnt_q  <= '0;
            imem_addr_q <= '0;
            cpu_rst_q   <= 1'b1;
            load_done_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            word_cnt_q  <= word_cnt_d;
            imem_addr_q <= imem_addr_d;
            cpu_rst_q   <= cpu_rst_d;
            load_done_q <= load_done_d;
        end
    end

    assign bus.imem_we    = word_ready;
    assign bus.imem_addr  = imem_addr_q;
    assign bus.imem_wdata = word;
    assign bus.cpu_rst    = cpu_rst_q;
    assign bus.load_done  = load_done_q;

endmodule

// File: tb/tb_prog_load_ctrl.sv
// Directed bench for prog_load_ctrl with a 4-word program.
module tb_prog_load_ctrl;

    localparam int CELLS = 4;
    localparam int AW    = 6;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   vec_cnt = 0;
    int   err_cnt = 0;

    logic [7:0]    prog  [16] = '{8'h08, 8'h00, 8'h00, 8'h00,
                                  8'h13, 8'h05, 8'h10, 8'h00,
                                  8'h93, 8'h05, 8'h20, 8'h00,
                                  8'h6f, 8'h00, 8'h00, 8'h00};
    logic [31:0]   exp_w [4]  = '{32'h00000008, 32'h00100513,
                                  32'h00200593, 32'h0000006f};

    logic [AW-1:0] log_addr [$];
    logic [31:0]   log_data [$];
    int            dbl_cnt = 0;
    logic          we_prev = 1'b0;

    prog_load_ctrl_if #(.ADDR_W(AW)) bus ();

    prog_load_ctrl #(.CELL_NUMBERS(CELLS), .ADDR_W(AW)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (bus.imem_we) begin
            log_addr.push_back(bus.imem_addr);
            log_data.push_back(bus.imem_wdata);
            if (we_prev) dbl_cnt++;
        end
        we_prev = bus.imem_we;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send_byte(input logic [7:0] b);
        bus.rx_valid = 1'b1;
        bus.rx_data  = b;
        tick();
        bus.rx_valid = 1'b0;
    endtask

    task automatic clear_log();
        log_addr.delete();
        log_data.delete();
        dbl_cnt = 0;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        tick();
        tick();
        rst = 1'b0;
    endtask

    task automatic check_program(input string tag);
        vec_cnt++;
        if (log_data.size() !== CELLS) begin
            err_cnt++;
            $display("FAIL %s write_count: got %0d expected %0d", tag, log_data.size(), CELLS);
        end
        for (int i = 0; i < CELLS; i++) begin
            if (i < log_data.size()) begin
                vec_cnt++;
                if (log_addr[i] !== AW'(i)) begin
                    err_cnt++;
                    $display("FAIL %s addr[%0d]: got %0d expected %0d", tag, i, log_addr[i], i);
                end
                vec_cnt++;
                if (log_data[i] !== exp_w[i]) begin
                    err_cnt++;
                    $display("FAIL %s data[%0d]: got %h expected %h", tag, i, log_data[i], exp_w[i]);
                end
            end
        end
        vec_cnt++;
        if (dbl_cnt !== 0) begin
            err_cnt++;
            $display("FAIL %s we_isolated: got %0d back-to-back pulses expected 0", tag, dbl_cnt);
        end
    endtask

    task automatic check_reset_vals(input string tag);
        vec_cnt++;
        if (bus.cpu_rst !== 1'b1) begin err_cnt++; $display("FAIL %s cpu_rst: got %b expected 1", tag, bus.cpu_rst); end
        vec_cnt++;
        if (bus.load_done !== 1'b0) begin err_cnt++; $display("FAIL %s load_done: got %b expected 0", tag, bus.load_done); end
        vec_cnt++;
        if (bus.imem_we !== 1'b0) begin err_cnt++; $display("FAIL %s imem_we: got %b expected 0", tag, bus.imem_we); end
        vec_cnt++;
        if (bus.imem_addr !== '0) begin err_cnt++; $display("FAIL %s imem_addr: got %h expected 0", tag, bus.imem_addr); end
        vec_cnt++;
        if (bus.imem_wdata !== 32'h0) begin err_cnt++; $display("FAIL %s imem_wdata: got %h expected 0", tag, bus.imem_wdata); end
    endtask

    task automatic test_reset();
        do_reset();
        check_reset_vals("reset");
    endtask

    task automatic test_load_gap();
        clear_log();
        for (int i = 0; i < 16; i++) begin
            send_byte(prog[i]);
            if (i % 4 == 3) begin
                vec_cnt++;
                if (bus.imem_we !== 1'b1) begin err_cnt++; $display("FAIL gap we_pulse[%0d]: got %b expected 1", i / 4, bus.imem_we); end
                vec_cnt++;
                if (bus.imem_addr !== AW'(i / 4)) begin err_cnt++; $display("FAIL gap we_addr[%0d]: got %0d expected %0d", i / 4, bus.imem_addr, i / 4); end
                vec_cnt++;
                if (bus.imem_wdata !== exp_w[i / 4]) begin err_cnt++; $display("FAIL gap we_data[%0d]: got %h expected %h", i / 4, bus.imem_wdata, exp_w[i / 4]); end
            end
            if (i == 15) begin
                vec_cnt++;
                if (bus.cpu_rst !== 1'b1) begin err_cnt++; $display("FAIL gap flush_cpu_rst: got %b expected 1", bus.cpu_rst); end
                tick();
                vec_cnt++;
                if (bus.cpu_rst !== 1'b0) begin err_cnt++; $display("FAIL gap run_cpu_rst: got %b expected 0", bus.cpu_rst); end
                vec_cnt++;
                if (bus.load_done !== 1'b1) begin err_cnt++; $display("FAIL gap run_load_done: got %b expected 1", bus.load_done); end
            end else begin
                repeat (3) tick();
            end
        end
        tick();
        check_program("gap");
    endtask

    task automatic test_back_to_back();
        do_reset();
        clear_log();
        for (int i = 0; i < 16; i++) begin
            bus.rx_valid = 1'b1;
            bus.rx_data  = prog[i];
            tick();
        end
        bus.rx_valid = 1'b0;
        vec_cnt++;
        if (bus.load_done !== 1'b0) begin err_cnt++; $display("FAIL b2b flush_load_done: got %b expected 0", bus.load_done); end
        tick();
        vec_cnt++;
        if (bus.load_done !== 1'b1) begin err_cnt++; $display("FAIL b2b run_load_done: got %b expected 1", bus.load_done); end
        vec_cnt++;
        if (bus.cpu_rst !== 1'b0) begin err_cnt++; $display("FAIL b2b run_cpu_rst: got %b expected 0", bus.cpu_rst); end
        tick();
        check_program("b2b");
    endtask

    task automatic test_restart_mid();
        do_reset();
        for (int i = 0; i < 6; i++) send_byte(8'hff);
        bus.restart = 1'b1;
        tick();
        bus.restart = 1'b0;
        vec_cnt++;
        if (bus.cpu_rst !== 1'b1) begin err_cnt++; $display("FAIL restart_mid cpu_rst: got %b expected 1", bus.cpu_rst); end
        tick();
        clear_log();
        for (int i = 0; i < 16; i++) send_byte(prog[i]);
        repeat (2) tick();
        check_program("restart_mid");
    endtask

    task automatic test_restart_coincident();
        do_reset();
        send_byte(8'h11);
        send_byte(8'h22);
        bus.restart  = 1'b1;
        bus.rx_valid = 1'b1;
        bus.rx_data  = 8'hee;
        tick();
        bus.restart  = 1'b0;
        bus.rx_valid = 1'b0;
        clear_log();
        for (int i = 0; i < 16; i++) send_byte(prog[i]);
        repeat (2) tick();
        check_program("restart_coinc");
    endtask

    task automatic test_run_ignore();
        clear_log();
        vec_cnt++;
        if (bus.load_done !== 1'b1) begin err_cnt++; $display("FAIL run entry load_done: got %b expected 1", bus.load_done); end
        for (int i = 0; i < 8; i++) begin
            send_byte(8'h40 + 8'(i));
            vec_cnt++;
            if (bus.cpu_rst !== 1'b0) begin err_cnt++; $display("FAIL run cpu_rst[%0d]: got %b expected 0", i, bus.cpu_rst); end
        end
        tick();
        vec_cnt++;
        if (log_data.size() !== 0) begin err_cnt++; $display("FAIL run writes: got %0d expected 0", log_data.size()); end
        bus.restart = 1'b1;
        tick();
        bus.restart = 1'b0;
        vec_cnt++;
        if (bus.cpu_rst !== 1'b1) begin err_cnt++; $display("FAIL run restart_cpu_rst: got %b expected 1", bus.cpu_rst); end
        vec_cnt++;
        if (bus.load_done !== 1'b0) begin err_cnt++; $display("FAIL run restart_load_done: got %b expected 0", bus.load_done); end
    endtask

    task automatic test_rst_mid();
        do_reset();
        clear_log();
        for (int i = 0; i < 11; i++) send_byte(prog[i]);
        tick();
        vec_cnt++;
        if (log_data.size() !== 2) begin err_cnt++; $display("FAIL rst_mid pre_writes: got %0d expected 2", log_data.size()); end
        // reset lands on what would have been the 4th byte of word 2
        rst          = 1'b1;
        bus.rx_valid = 1'b1;
        bus.rx_data  = 8'h99;
        tick();
        bus.rx_valid = 1'b0;
        check_reset_vals("rst_mid");
        tick();
        rst = 1'b0;
        vec_cnt++;
        if (log_data.size() !== 2) begin err_cnt++; $display("FAIL rst_mid no_write: got %0d expected 2", log_data.size()); end
        clear_log();
        for (int i = 0; i < 16; i++) send_byte(prog[i]);
        repeat (2) tick();
        check_program("rst_mid_reload");
    endtask

    initial begin
        bus.rx_valid = 1'b0;
        bus.rx_data  = 8'h00;
        bus.restart  = 1'b0;
        test_reset();
        test_load_gap();
        test_back_to_back();
        test_restart_mid();
        test_restart_coincident();
        tick();
        test_run_ignore();
        test_rst_mid();
        $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
        $finish;
    end

endmodule
